// File: rtl/ex_mul_pkg.sv
// rtl/ex_mul_pkg.sv - shared encodings, state type and sizing helper for ex_mul_unit
//
// Contents:
//   MUL_LO / MUL_HSS / MUL_HSU / MUL_HUU : funct encodings (MUL, MULH, MULHSU, MULHU)
//   mul_state_t                          : iterative multiplier FSM states
//   mul_cnt_w()                          : width of the step counter for a given DATA_W/STEP
//   MUL_CNT_W                            : counter width for the default 32-bit, radix-4 build

package ex_mul_pkg;

    localparam logic [1:0] MUL_LO  = 2'd0;
    localparam logic [1:0] MUL_HSS = 2'd1;
    localparam logic [1:0] MUL_HSU = 2'd2;
    localparam logic [1:0] MUL_HUU = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // The counter must hold the value N = data_w/step itself, hence the +1.
    function automatic int mul_cnt_w(input int data_w, input int step);
        return $clog2(data_w / step + 1);
    endfunction

    localparam int MUL_CNT_W = mul_cnt_w(32, 2);

endpackage

// File: rtl/mul_radix_step.sv
// rtl/mul_radix_step.sv - one combinational radix-2^STEP accumulate step of the iterative multiplier
//
// Ports:
//   product      in  2*DATA_W  running unsigned product
//   a            in  DATA_W    multiplicand magnitude
//   b_chunk      in  STEP      current low STEP bits of the remaining multiplier
//   step_idx     in  CNT_W     index of this step (0 = least significant chunk)
//   product_next out 2*DATA_W  product + (b_chunk * a) << (step_idx * STEP)

module mul_radix_step
    import ex_mul_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEP   = 2,
    parameter int CNT_W  = 5
) (
    input  logic [2*DATA_W-1:0] product,
    input  logic [DATA_W-1:0]   a,
    input  logic [STEP-1:0]     b_chunk,
    input  logic [CNT_W-1:0]    step_idx,
    output logic [2*DATA_W-1:0] product_next
);

    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] partial;

    assign a_ext = {{DATA_W{1'b0}}, a};

    // Shift-and-add partial product for the STEP-bit chunk. The operands are
    // magnitudes, so the full-width sum never exceeds 2*DATA_W bits.
    always_comb begin
        partial = '0;
        for (int i = 0; i < STEP; i++) begin
            if (b_chunk[i]) begin
                partial = partial + (a_ext << i);
            end
        end
        product_next = product + (partial << (int'(step_idx) * STEP));
    end

endmodule

// File: rtl/ex_mul_unit.sv
// rtl/ex_mul_unit.sv - iterative MUL/MULH/MULHSU/MULHU unit for the execute stage
//
// Optional feature macro: EX_MUL_EARLY_OUT_EN (finish as soon as the remaining
// multiplier bits are all zero; default build runs a fixed DATA_W/STEP steps).
//
// Ports:
//   clk       in  1       clock, rising edge
//   arst_n    in  1       asynchronous active-low reset
//   start_i   in  1       ID/EX holds a valid multiply
//   funct_i   in  2       0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
//   op_a_i    in  DATA_W  rs1 value
//   op_b_i    in  DATA_W  rs2 value
//   flush_i   in  1       kill the instruction in EX
//   stall_o   out 1       hold ID/EX and earlier stages
//   done_o    out 1       result_o valid this cycle
//   result_o  out DATA_W  selected product half

module ex_mul_unit
    import ex_mul_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEP   = 2
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start_i,
    input  logic [1:0]        funct_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o
);

    localparam int              N     = DATA_W / STEP;
    localparam int              CNT_W = mul_cnt_w(DATA_W, STEP);
    localparam logic [CNT_W-1:0] CNT_N = CNT_W'(N);

    mul_state_t          state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic                neg_q, neg_d;
    logic [1:0]          funct_q, funct_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   result_q, result_d;

    logic                a_signed, b_signed;
    logic [DATA_W-1:0]   a_abs, b_abs;
    logic [DATA_W-1:0]   b_shift;
    logic [CNT_W-1:0]    step_idx;
    logic [2*DATA_W-1:0] prod_step;
    logic [2*DATA_W-1:0] prod_final;
    logic                last_step;

    // Launch-time operand conditioning: the datapath works on magnitudes and
    // the sign is reapplied once at the end.
    assign a_signed = (funct_i == MUL_HSS) || (funct_i == MUL_HSU);
    assign b_signed = (funct_i == MUL_HSS);
    assign a_abs    = (a_signed && op_a_i[DATA_W-1]) ? -op_a_i : op_a_i;
    assign b_abs    = (b_signed && op_b_i[DATA_W-1]) ? -op_b_i : op_b_i;

    // cnt_q counts N..1 while busy, so the chunk index runs 0..N-1.
    assign step_idx = CNT_N - cnt_q;
    assign b_shift  = b_q >> STEP;

    mul_radix_step #(
        .DATA_W (DATA_W),
        .STEP   (STEP),
        .CNT_W  (CNT_W)
    ) u_step (
        .product      (prod_q),
        .a            (a_q),
        .b_chunk      (b_q[STEP-1:0]),
        .step_idx     (step_idx),
        .product_next (prod_step)
    );

`ifdef EX_MUL_EARLY_OUT_EN
    // Once no multiplier bits remain, further steps would only add zero.
    assign last_step = (cnt_q == CNT_W'(1)) || (b_shift == '0);
`else
    assign last_step = (cnt_q == CNT_W'(1));
`endif

    assign prod_final = neg_q ? -prod_step : prod_step;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        funct_d  = funct_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start_i && !flush_i) begin
                    state_d = BUSY;
                    a_d     = a_abs;
                    b_d     = b_abs;
                    neg_d   = (a_signed & op_a_i[DATA_W-1]) ^ (b_signed & op_b_i[DATA_W-1]);
                    funct_d = funct_i;
                    prod_d  = '0;
                    cnt_d   = CNT_N;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    prod_d = prod_step;
                    b_d    = b_shift;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (last_step) begin
                        state_d  = DONE;
                        result_d = (funct_q == MUL_LO) ? prod_final[DATA_W-1:0]
                                                       : prod_final[2*DATA_W-1:DATA_W];
                    end
                end
            end
            // The instruction that just finished still sits in ID/EX, so
            // start_i is deliberately not looked at here.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            funct_q  <= 2'd0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            funct_q  <= funct_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Combinational so ID/EX freezes in the launch cycle itself; gated by
    // reset so the output is 0 while reset is held even if start_i is high.
    assign stall_o  = arst_n & (((state_q == IDLE) & start_i & ~flush_i) | (state_q == BUSY));
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_ex_mul_unit.sv
// tb/tb_ex_mul_unit.sv - self-checking scoreboard testbench for ex_mul_unit

module tb_ex_mul_unit;

    localparam int DATA_W = 32;
    localparam int STEP   = 2;
    localparam int N      = DATA_W / STEP;

    logic              clk;
    logic              arst_n;
    logic              start_i;
    logic [1:0]        funct_i;
    logic [DATA_W-1:0] op_a_i;
    logic [DATA_W-1:0] op_b_i;
    logic              flush_i;
    logic              stall_o;
    logic              done_o;
    logic [DATA_W-1:0] result_o;

    int                checks;
    int                passes;
    int                done_total;
    logic [DATA_W-1:0] sb_q[$];
    logic [DATA_W-1:0] last_exp;

    ex_mul_unit #(
        .DATA_W (DATA_W),
        .STEP   (STEP)
    ) dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .start_i  (start_i),
        .funct_i  (funct_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference product built from sign/zero-extended 64-bit operands.
    function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ae, be, p;
        ae = (f == 2'd1 || f == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        be = (f == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ae * be;
        return (f == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Cycle index (launch = 0) at which done_o is expected.
    function automatic int exp_lat(input logic [1:0] f, input logic [31:0] b);
`ifdef EX_MUL_EARLY_OUT_EN
        logic [31:0] mag;
        int          bits;
        int          steps;
        mag  = (f == 2'd1 && b[31]) ? -b : b;
        bits = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) bits = i + 1;
        steps = (bits + STEP - 1) / STEP;
        if (steps < 1) steps = 1;
        return steps + 1;
`else
        return (f == f) ? N + 1 : N + 1;
`endif
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest pending result.
    always @(negedge clk) begin
        if (arst_n && done_o) begin
            done_total++;
            chk("sb_pending", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) chk("result", 64'(result_o), 64'(sb_q.pop_front()));
        end
    end

    task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int cyc;
        int lat;
        int done_cyc;
        lat      = exp_lat(f, b);
        done_cyc = -1;
        @(posedge clk); #1;
        start_i = 1'b1; funct_i = f; op_a_i = a; op_b_i = b;
        sb_q.push_back(exp);
        last_exp = exp;
        cyc = 0;
        while (done_cyc < 0 && cyc < 64) begin
            @(negedge clk);
            if (done_o) begin
                done_cyc = cyc;
                chk("stall_in_done", 64'(stall_o), 64'd0);
            end else begin
                chk("stall_busy", 64'(stall_o), 64'd1);
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("latency", 64'(done_cyc), 64'(lat));
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        chk("stall_after", 64'(stall_o), 64'd0);
    endtask

    initial begin
        int          cyc;
        int          pulses;
        int          d1;
        int          d2;
        int          done_before;
        logic [31:0] ra, rb;
        logic [1:0]  rf;

        checks = 0; passes = 0; done_total = 0; last_exp = '0;
        arst_n = 1'b0; start_i = 1'b0; funct_i = 2'd0;
        op_a_i = '0; op_b_i = '0; flush_i = 1'b0;

        #2;
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_result", 64'(result_o), 64'd0);
        @(posedge clk); #1;
        arst_n = 1'b1;

        run_op(2'd0, 32'd7, 32'd6, 32'h0000002A);
        run_op(2'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1);
        run_op(2'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF);
        run_op(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op(2'd1, 32'h80000000, 32'h80000000, 32'h40000000);
        run_op(2'd1, 32'h00000003, 32'hFFFFFFFB, 32'hFFFFFFFF);
        run_op(2'd0, 32'h12345678, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            ra = $urandom; rb = $urandom; rf = 2'($urandom_range(0, 3));
            run_op(rf, ra, rb, model(rf, ra, rb));
        end

        // Back-to-back: start_i held through DONE, operands change after it.
        done_before = done_total;
        pulses = 0; d1 = -1; d2 = -1; cyc = 0;
        @(posedge clk); #1;
        start_i = 1'b1; funct_i = 2'd0; op_a_i = 32'd2; op_b_i = 32'd3;
        sb_q.push_back(32'd6);
        while (pulses < 2 && cyc < 100) begin
            @(negedge clk);
            if (done_o) begin
                pulses++;
                if (pulses == 1) d1 = cyc; else d2 = cyc;
                chk("b2b_done_stall", 64'(stall_o), 64'd0);
            end
            @(posedge clk); #1;
            cyc++;
            if (pulses == 1 && cyc == d1 + 1) begin
                op_a_i = 32'd4; op_b_i = 32'd5;
                sb_q.push_back(32'd20);
            end
        end
        start_i = 1'b0;
        last_exp = 32'd20;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("b2b_first_lat", 64'(d1), 64'(exp_lat(2'd0, 32'd3)));
        chk("b2b_second_lat", 64'(d2), 64'(d1 + 1 + exp_lat(2'd0, 32'd5)));
        chk("b2b_pulses", 64'(done_total - done_before), 64'd2);
        chk("b2b_sb_empty", 64'(sb_q.size()), 64'd0);

        // Flush in BUSY at cycle 5.
        done_before = done_total;
        @(posedge clk); #1;
        start_i = 1'b1; funct_i = 2'd0; op_a_i = 32'd9; op_b_i = 32'd9;
        repeat (5) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_cycle_stall", 64'(stall_o), 64'd1);
        @(posedge clk); #1;
        flush_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        chk("flush_stall_drop", 64'(stall_o), 64'd0);
        chk("flush_no_done", 64'(done_o), 64'd0);
        chk("flush_result_kept", 64'(result_o), 64'(last_exp));
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("flush_no_pulse", 64'(done_total - done_before), 64'd0);
        chk("flush_result_hold", 64'(result_o), 64'(last_exp));

        // Asynchronous reset mid-operation at cycle 8, start_i still high.
        @(posedge clk); #1;
        start_i = 1'b1; funct_i = 2'd0; op_a_i = 32'd7; op_b_i = 32'd6;
        repeat (8) begin @(posedge clk); #1; end
        arst_n = 1'b0;
        #1;
        chk("arst_stall", 64'(stall_o), 64'd0);
        chk("arst_done", 64'(done_o), 64'd0);
        chk("arst_result", 64'(result_o), 64'd0);
        start_i = 1'b0;
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_stall", 64'(stall_o), 64'd0);
        run_op(2'd0, 32'd7, 32'd6, 32'h0000002A);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ex_mul_unit.md
# ex_mul_unit

Iterative integer multiplier for the execute stage of the basic pipeline, consuming operands and multiply control straight out of the ID/EX pipeline register. It computes RV-style MUL/MULH/MULHSU/MULHU over several cycles. While busy it drives a stall that holds the ID/EX and upstream registers (their `en` low). It presents the selected half of the product, together with a one-cycle done pulse, to the EX/MEM path.

## Interface
- `DATA_W`, 32, operand and result width
- `STEP`, 2, multiplier bits retired per cycle; must divide `DATA_W` (legal 1, 2, 4)
- `clk`  in  1  clock; all state on rising edge
- `arst_n`  in  1  asynchronous, active-low reset
- `start_i`  in  1  ID/EX holds a valid multiply instruction
- `funct_i`  in  2  0=MUL (low half), 1=MULH (s×s high), 2=MULHSU (s×u high), 3=MULHU (u×u high)
- `op_a_i`  in  DATA_W  rs1 value (ID/EX `dreg1`)
- `op_b_i`  in  DATA_W  rs2 value (ID/EX `dreg2`)
- `flush_i`  in  1  kill instruction in EX (branch taken downstream)
- `stall_o`  out  1  hold ID/EX and earlier stages
- `done_o`  out  1  `result_o` valid this cycle
- `result_o`  out  DATA_W  selected product half

## Operation
- States: IDLE, BUSY, DONE. Reset values: state=IDLE, `stall_o`=0, `done_o`=0, `result_o`=0, and all internal registers 0.
- Ops are launched only from IDLE:
  - IDLE with `start_i`=1 and `flush_i`=0 moves to BUSY.
  - The launch captures |a| and |b| per signedness, `neg` = sign(a) XOR sign(b) for signed operands only, `funct`, product=0, and count=N where N = `DATA_W/STEP`.
- Signedness:
  - `op_a` is signed for funct 1 and 2.
  - `op_b` is signed for funct 1 only.
  - MUL is computed as unsigned; the low half is identical either way.
- Each BUSY cycle:
  - product += (b[STEP-1:0] × a) << (shift position).
  - b >>= STEP, count -= 1.
  - Product width is 2·DATA_W and accumulation never truncates.
- BUSY with count reaching 0 moves to DONE. On that same edge, `result_o` is loaded with the half of (neg ? −product : product) selected by funct: low half for MUL, high half otherwise. Negation is two's complement over 2·DATA_W.
- DONE always moves to IDLE.
  - `start_i` is ignored in DONE, because the same instruction is still in ID/EX.
  - `result_o` holds its value until the next DONE load.
- `stall_o` = (IDLE & `start_i` & ~`flush_i`) | BUSY. It is combinational, so ID/EX is frozen from the launch cycle onward.
- `done_o` = (state==DONE).
- `flush_i` in BUSY moves to IDLE next cycle:
  - `done_o` is not asserted and `result_o` is unchanged.
  - `stall_o` stays high in the flush cycle and drops the cycle after.
- `flush_i` in DONE has no effect on the FSM; the downstream stage discards the result.

## Timing
- Launch at cycle 0 gives BUSY for cycles 1..N and DONE at cycle N+1. `stall_o` is high on cycles 0..N and low at N+1. With defaults, N=16 and the op stalls for 17 cycles.
- In the DONE cycle the pipeline advances: ID/EX loads the next instruction, and EX/MEM captures `result_o`.
- Back-to-back multiplies: the next `start_i` is seen in IDLE at cycle N+2, one bubble-free cycle after DONE.
- Reset asserted at any point returns the block to IDLE with all outputs 0 immediately. An in-flight op is lost.

## Configuration
- `EX_MUL_EARLY_OUT_EN` defined:
  - BUSY also moves to DONE when the remaining shifted `b` is zero after the current step.
  - The result is identical. Latency = ceil(bitlen(|b|)/STEP)+1 cycles, with a minimum of 2 (one BUSY cycle).
- Not defined: the fixed N BUSY cycles always apply, giving deterministic latency.

## Structure
- Shared package `ex_mul_pkg`:
  - funct encodings `MUL_LO`, `MUL_HSS`, `MUL_HSU`, `MUL_HUU`.
  - state enum `mul_state_t`.
  - helper constant `MUL_CNT_W` = clog2(DATA_W/STEP + 1).
- One sub-module: `mul_radix_step`, combinational. It takes (product, a, b-chunk, step index) and returns the next product. It contains the STEP-bit partial-product generation and the 2·DATA_W adder.

## Test plan
Defaults apply unless stated (DATA_W=32, STEP=2, macro undefined).
- MUL 7×6, start at cycle 0 → `stall_o` high on cycles 0–16; at cycle 17, `done_o`=1 and `result_o`=0x0000002A.
- MUL and MULH with a=−3 (0xFFFFFFFD), b=5 → MUL gives 0xFFFFFFF1; MULH gives 0xFFFFFFFF.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=0xFFFFFFFF (−1), b=0xFFFFFFFF → 0xFFFFFFFF.
- Two consecutive MULs (2×3, then 4×5), with `start_i` held through DONE → exactly two `done_o` pulses, carrying 6 then 20, with no relaunch on the DONE cycle.
- `flush_i` at cycle 5 of a MUL → state IDLE at cycle 6, `stall_o`=0 from cycle 6, no `done_o`, and `result_o` keeps its previous value.
- `arst_n` low at cycle 8 mid-op → `stall_o`, `done_o` and `result_o` read 0 immediately. With `EX_MUL_EARLY_OUT_EN` and MUL 7×6: DONE at cycle 3 with result 0x2A.
